keypad_entry_ctrl: RTL and testbench

- Parametrised successor to the keypad/decoder/sequence chain: scans a 4x4 matrix keypad and debounces the result.
- Emits exactly one clean strobe per key press, replacing the slow_clk & button trigger.
- Shifts accepted key codes into a DIGITS-deep entry buffer that feeds the seven-segment path and the combo-lock compare.

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/keypad_debounce.sv | 145 ++++++++++++++
 rtl/keypad_entry_ctrl.sv | 120 ++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner, debouncer and entry buffer.
// Optional auto-repeat is enabled with the KEYPAD_REPEAT_EN macro.
package keypad_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_KEYS = 16;

  localparam logic [KEY_W-1:0] KEY_NONE = 4'h0;

  // Pmod KYPD key codes, nibble index {col,row}: col0=1,4,7,0 col1=2,5,8,F col2=3,6,9,E col3=A,B,C,D
  localparam logic [KEY_W*NUM_KEYS-1:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } deb_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } sweep_class_e;

  typedef struct packed {
    sweep_class_e     cls;
    logic [KEY_W-1:0] code;
  } sweep_info_t;

  // Count active-low hits in a full sweep and report the code when exactly one is present.
  function automatic sweep_info_t classify_sweep(input logic [NUM_KEYS-1:0] sweep);
    sweep_info_t info;
    logic [4:0]  lows;
    lows      = '0;
    info.cls  = CLS_NONE;
    info.code = KEY_NONE;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!sweep[i]) begin
        lows      = lows + 5'd1;
        info.code = KEY_MAP[KEY_W*i +: KEY_W];
      end
    end
    if (lows == 5'd1) begin
      info.cls = CLS_SINGLE;
    end else if (lows > 5'd1) begin
      info.cls = CLS_MULTI;
    end
    return info;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-level press/release debouncer producing one accept strobe per clean key press.
// With KEYPAD_REPEAT_EN defined, a held key re-issues the strobe after REPEAT_SCANS sweeps.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 250
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sweep_done,
  input  sweep_class_e     sweep_cls,
  input  logic [KEY_W-1:0] sweep_code,
  output logic             accept,
  output logic [KEY_W-1:0] accept_code
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam bit               INSTANT  = (DEBOUNCE_CNT == 1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      RPT_W      = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_FULL   = RPT_W'(REPEAT_SCANS);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'((REPEAT_SCANS / 4 == 0) ? 1 : REPEAT_SCANS / 4);

  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             accept_q, accept_d;
  logic [KEY_W-1:0] code_q, code_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= KEY_NONE;
      accept_q <= 1'b0;
      code_q   <= KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= RPT_FULL;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      accept_q <= accept_d;
      code_q   <= code_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= rpt_d;
`endif
    end
  end

  // The FSM only advances on a completed sweep; the strobe lands the cycle after.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;
    code_d   = code_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d    = rpt_q;
`endif
    if (sweep_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sweep_cls == CLS_SINGLE) begin
            cand_d = sweep_code;
            cnt_d  = CNT_ONE;
            if (INSTANT) begin
              state_d  = ST_HELD;
              accept_d = 1'b1;
              code_d   = sweep_code;
`ifdef KEYPAD_REPEAT_EN
              rpt_d    = RPT_FULL;
`endif
            end else begin
              state_d = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (sweep_cls == CLS_SINGLE && sweep_code == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d  = ST_HELD;
              accept_d = 1'b1;
              code_d   = cand_q;
`ifdef KEYPAD_REPEAT_EN
              rpt_d    = RPT_FULL;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (sweep_cls == CLS_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = INSTANT ? ST_IDLE : ST_RELEASE_CHK;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = RPT_FULL;
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          else if (sweep_cls == CLS_MULTI) begin
            rpt_d = RPT_FULL;
          end else if (rpt_q == RPT_ONE) begin
            accept_d = 1'b1;
            code_d   = cand_q;
            rpt_d    = RPT_RELOAD;
          end else begin
            rpt_d = rpt_q - RPT_ONE;
          end
`endif
        end
        ST_RELEASE_CHK: begin
          if (sweep_cls == CLS_NONE) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign accept      = accept_q;
  assign accept_code = code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// 4x4 matrix keypad scanner with debounced key strobe and a DIGITS-deep shifting entry buffer.
// Defining KEYPAD_REPEAT_EN adds auto-repeat of a held key (REPEAT_SCANS parameter).
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned DIGITS       = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 250
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [3:0]                   col_out,
  input  logic [3:0]                   row_in,
  input  logic                         clr,
  output logic                         key_valid,
  output logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          entry_data,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count,
  output logic                         entry_full
);

  localparam int unsigned       DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int unsigned       DATA_W   = 4 * DIGITS;
  localparam int unsigned       ECNT_W   = $clog2(DIGITS + 1);
  localparam logic [ECNT_W-1:0] ECNT_MAX = ECNT_W'(DIGITS);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_q, col_d;
  logic [3:0]          col_out_q, col_out_d;
  logic [NUM_KEYS-1:0] sweep_q, sweep_d;
  logic                sweep_done_q, sweep_done_d;
  logic [DATA_W-1:0]   entry_data_q, entry_data_d;
  logic [ECNT_W-1:0]   entry_count_q, entry_count_d;
  logic                entry_full_q, entry_full_d;

  sweep_info_t         sweep_info;
  logic                accept;
  logic [KEY_W-1:0]    accept_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      col_q         <= 2'd0;
      col_out_q     <= 4'b1110;
      sweep_q       <= '1;
      sweep_done_q  <= 1'b0;
      entry_data_q  <= '0;
      entry_count_q <= '0;
      entry_full_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      col_out_q     <= col_out_d;
      sweep_q       <= sweep_d;
      sweep_done_q  <= sweep_done_d;
      entry_data_q  <= entry_data_d;
      entry_count_q <= entry_count_d;
      entry_full_q  <= entry_full_d;
    end
  end

  // Column dwell: sample rows at the end of each dwell, then advance to the next column.
  always_comb begin
    div_d        = div_q + DIV_W'(1);
    col_d        = col_q;
    col_out_d    = col_out_q;
    sweep_d      = sweep_q;
    sweep_done_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d                       = '0;
      sweep_d[{col_q, 2'b00} +: 4] = row_in;
      col_d                       = col_q + 2'd1;
      col_out_d                   = {col_out_q[2:0], col_out_q[3]};
      sweep_done_d                = (col_q == 2'd3);
    end
  end

  assign sweep_info = classify_sweep(sweep_q);

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS (REPEAT_SCANS)
`endif
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sweep_done  (sweep_done_q),
    .sweep_cls   (sweep_info.cls),
    .sweep_code  (sweep_info.code),
    .accept      (accept),
    .accept_code (accept_code)
  );

  // Entry buffer: clear wins over a same-cycle accept; shift-in saturates the count.
  always_comb begin
    entry_data_d  = entry_data_q;
    entry_count_d = entry_count_q;
    if (clr) begin
      entry_data_d  = '0;
      entry_count_d = '0;
    end else if (accept) begin
      entry_data_d  = (entry_data_q << 4) | DATA_W'(accept_code);
      entry_count_d = (entry_count_q == ECNT_MAX) ? entry_count_q : entry_count_q + ECNT_W'(1);
    end
    entry_full_d = (entry_count_d == ECNT_MAX);
  end

  assign col_out     = col_out_q;
  assign key_valid   = accept;
  assign key_code    = accept_code;
  assign entry_data  = entry_data_q;
  assign entry_count = entry_count_q;
  assign entry_full  = entry_full_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: keypad matrix model, sweep-level reference model, strobe scoreboard.
// Repeat scenario is compiled in when KEYPAD_REPEAT_EN is defined.
module tb_keypad_entry_ctrl;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 3;
  localparam int unsigned DIGITS       = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REPEAT_SCANS = 8;
`endif
  localparam int SWEEP_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_data;
  logic [2:0]  entry_count;
  logic        entry_full;

  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } strobe_t;

  strobe_t obs_q[$];
  strobe_t exp_q[$];

  // Reference model state (sweep granularity)
  int          sweep_idx;
  bit          held;
  logic [3:0]  streak_code;
  int          streak_len;
  int          none_len;
  logic [15:0] exp_data;
  int          exp_count;
`ifdef KEYPAD_REPEAT_EN
  int          rpt_left;
`endif

  keypad_entry_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .DIGITS       (DIGITS)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_SCANS (REPEAT_SCANS)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_out     (col_out),
    .row_in      (row_in),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_data  (entry_data),
    .entry_count (entry_count),
    .entry_full  (entry_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    strobe_t s;
    if (!reset && key_valid) begin
      s.cyc  = cyc;
      s.code = key_code;
      obs_q.push_back(s);
    end
  end

  // Passive matrix: a pressed key shorts its row to the driven (low) column.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[4*c+r]) row_in[r] = 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] key_at(input int idx);
    case (idx)
      0: return 4'h1;   1: return 4'h4;   2: return 4'h7;   3: return 4'h0;
      4: return 4'h2;   5: return 4'h5;   6: return 4'h8;   7: return 4'hF;
      8: return 4'h3;   9: return 4'h6;  10: return 4'h9;  11: return 4'hE;
      12: return 4'hA; 13: return 4'hB;  14: return 4'hC;  15: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [15:0] key_mask(input logic [3:0] k);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (key_at(i) == k) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_init();
    sweep_idx   = 0;
    held        = 1'b0;
    streak_code = 4'h0;
    streak_len  = 0;
    none_len    = 0;
    exp_data    = '0;
    exp_count   = 0;
`ifdef KEYPAD_REPEAT_EN
    rpt_left    = REPEAT_SCANS;
`endif
    obs_q.delete();
    exp_q.delete();
  endtask

  // One sweep of the keypad as the user sees it: press needs DEBOUNCE_CNT identical
  // single-key sweeps, release needs DEBOUNCE_CNT empty sweeps.
  task automatic model_sweep(input logic [15:0] keys);
    int         n;
    logic [3:0] code;
    bit         strobe;
    strobe_t    e;
    n      = $countones(keys);
    code   = 4'h0;
    strobe = 1'b0;
    for (int i = 0; i < 16; i++) if (keys[i]) code = key_at(i);
    sweep_idx++;
    if (!held) begin
      if (n == 1 && streak_len > 0 && code == streak_code) begin
        streak_len++;
      end else if (n == 1 && streak_len == 0) begin
        streak_code = code;
        streak_len  = 1;
      end else begin
        streak_len = 0;
      end
      if (streak_len == DEBOUNCE_CNT) begin
        strobe   = 1'b1;
        held     = 1'b1;
        none_len = 0;
`ifdef KEYPAD_REPEAT_EN
        rpt_left = REPEAT_SCANS;
`endif
      end
    end else if (n == 0) begin
      none_len++;
`ifdef KEYPAD_REPEAT_EN
      rpt_left = REPEAT_SCANS;
`endif
      if (none_len == DEBOUNCE_CNT) begin
        held       = 1'b0;
        streak_len = 0;
      end
    end else if (none_len > 0) begin
      none_len = 0;
    end
`ifdef KEYPAD_REPEAT_EN
    else if (n > 1) begin
      rpt_left = REPEAT_SCANS;
    end else begin
      rpt_left--;
      if (rpt_left == 0) begin
        strobe   = 1'b1;
        rpt_left = (REPEAT_SCANS / 4 == 0) ? 1 : REPEAT_SCANS / 4;
      end
    end
`endif
    if (strobe) begin
      e.cyc  = SWEEP_CYC * sweep_idx + 1;
      e.code = streak_code;
      exp_q.push_back(e);
      exp_data = (exp_data << 4) | {12'h000, streak_code};
      if (exp_count < DIGITS) exp_count++;
    end
  endtask

  // Called at a negedge where the next posedge starts a fresh sweep.
  task automatic run_sweep(input logic [15:0] keys);
    pressed = keys;
    model_sweep(keys);
    repeat (SWEEP_CYC) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_sweeps(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_sweep(keys);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    clr     = 1'b0;
    pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col_out: got %b exp 1110", col_out); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b exp 0", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h exp 0", key_code); end
    if (entry_data !== 16'h0) begin errors++; $display("FAIL reset_entry_data: got %h exp 0000", entry_data); end
    if (entry_count !== 3'd0) begin errors++; $display("FAIL reset_entry_count: got %0d exp 0", entry_count); end
    if (entry_full !== 1'b0) begin errors++; $display("FAIL reset_entry_full: got %b exp 0", entry_full); end
    reset = 1'b0;
    model_init();
  endtask

  task automatic check_strobes(input string name);
    strobe_t e;
    strobe_t o;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s_strobe: got none, exp code %h at cycle %0d", name, e.code, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.code !== e.code) begin
          errors++;
          $display("FAIL %s_strobe: got code %h at cycle %0d, exp code %h at cycle %0d",
                   name, o.code, o.cyc, e.code, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].cyc <= cyc) begin
      errors++;
      $display("FAIL %s_extra_strobe: got %0d unexpected strobe(s), first code %h at cycle %0d, exp 0",
               name, obs_q.size(), obs_q[0].code, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic check_entry(input string name);
    checks += 3;
    if (entry_data !== exp_data) begin
      errors++; $display("FAIL %s_entry_data: got %h exp %h", name, entry_data, exp_data);
    end
    if (int'(entry_count) != exp_count) begin
      errors++; $display("FAIL %s_entry_count: got %0d exp %0d", name, entry_count, exp_count);
    end
    if (entry_full !== (exp_count == DIGITS)) begin
      errors++; $display("FAIL %s_entry_full: got %b exp %b", name, entry_full, exp_count == DIGITS);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    do_reset();
    for (int s = 0; s < 3; s++) model_sweep('0);
    for (int k = 0; k < 3 * SWEEP_CYC; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = 4'b1111 & ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
      checks += 2;
      if (col_out !== exp_col) begin
        errors++; $display("FAIL scan_col_out: cycle %0d got %b exp %b", cyc, col_out, exp_col);
      end
      if (key_valid !== 1'b0) begin
        errors++; $display("FAIL idle_key_valid: cycle %0d got %b exp 0", cyc, key_valid);
      end
    end
    check_entry("idle");
  endtask

  task automatic test_single_key();
    do_reset();
    run_sweeps(key_mask(4'h6), 3);
    run_sweeps(key_mask(4'h6), 10);
    run_sweeps('0, 3);
    check_strobes("single");
    check_entry("single");
    checks += 2;
    if (entry_data !== 16'h0006) begin errors++; $display("FAIL single_data_const: got %h exp 0006", entry_data); end
    if (key_code !== 4'h6) begin errors++; $display("FAIL single_key_code: got %h exp 6", key_code); end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [5];
    seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    do_reset();
    foreach (seq[i]) begin
      run_sweeps(key_mask(seq[i]), 3);
      run_sweeps('0, 3);
    end
    check_strobes("sequence");
    check_entry("sequence");
    checks += 3;
    if (entry_data !== 16'h23A5) begin errors++; $display("FAIL sequence_data_const: got %h exp 23a5", entry_data); end
    if (entry_count !== 3'd4) begin errors++; $display("FAIL sequence_count_const: got %0d exp 4", entry_count); end
    if (entry_full !== 1'b1) begin errors++; $display("FAIL sequence_full_const: got %b exp 1", entry_full); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 6; i++) run_sweep((i % 2 == 0) ? key_mask(4'h8) : 16'h0000);
    run_sweeps(key_mask(4'h8), 3);
    run_sweeps('0, 3);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d strobes exp 1", obs_q.size()); end
    check_strobes("bounce");
    run_sweeps(key_mask(4'h1) | key_mask(4'h2), 10);
    run_sweeps('0, 3);
    check_strobes("multi");
    check_entry("bounce");
  endtask

  task automatic test_clr();
    do_reset();
    run_sweeps(key_mask(4'h1), 3);
    run_sweeps('0, 3);
    run_sweeps(key_mask(4'h2), 3);
    run_sweeps('0, 3);
    check_entry("clr_pre");
    run_sweeps(key_mask(4'h7), 3);
    model_sweep(key_mask(4'h7));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h7) begin
      errors++; $display("FAIL clr_strobe_cycle: got valid %b code %h exp valid 1 code 7", key_valid, key_code);
    end
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr       = 1'b0;
    exp_data  = '0;
    exp_count = 0;
    check_entry("clr");
    checks++;
    if (key_code !== 4'h7) begin errors++; $display("FAIL clr_key_code: got %h exp 7", key_code); end
    repeat (SWEEP_CYC - 2) @(posedge clk);
    @(negedge clk);
    run_sweeps('0, 3);
    check_strobes("clr");
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL midsweep_reset_col: got %b exp 1110", col_out); end
  endtask

  task automatic test_random();
    logic [15:0] one;
    logic [15:0] pat;
    int          r;
    int          a;
    int          b;
    one = 16'h0001;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (r < 4)      pat = '0;
      else if (r < 9) pat = one << a;
      else            pat = (one << a) | (one << b);
      run_sweeps(pat, $urandom_range(1, 5));
      if (n % 10 == 9) check_strobes("random");
    end
    run_sweeps('0, 4);
    check_strobes("random");
    check_entry("random");
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    do_reset();
    run_sweeps(key_mask(4'hD), 20);
    run_sweeps('0, 3);
    checks++;
    if (obs_q.size() != 6) begin errors++; $display("FAIL repeat_count: got %0d strobes exp 6", obs_q.size()); end
    check_strobes("repeat");
    check_entry("repeat");
  endtask
`endif

  initial begin
    reset   = 1'b1;
    clr     = 1'b0;
    pressed = '0;
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_clr();
    test_random();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
